// File: rtl/goldschmidt_pkg.sv
// Shared types and constants for the Goldschmidt divider control path.
//   gs_state_t   : sequencing FSM states
//   ND_SEL_*     : numerator/denominator operand select encodings
//   KSEL_*       : k-source select encodings
//   ONE_Q15      : 1.0 in Q1.15, the value newD converges towards
package goldschmidt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInitN,
    StInitD,
    StIterN,
    StIterD,
    StDone
  } gs_state_t;

  localparam logic [1:0] ND_SEL_D    = 2'd0;
  localparam logic [1:0] ND_SEL_N    = 2'd1;
  localparam logic [1:0] ND_SEL_NEWD = 2'd2;
  localparam logic [1:0] ND_SEL_NEWN = 2'd3;

  localparam logic KSEL_IA   = 1'b0;
  localparam logic KSEL_PREV = 1'b1;

  localparam logic [15:0] ONE_Q15 = 16'h8000;

endpackage

// File: rtl/gs_iter_counter.sv
// Refinement-iteration counter for the Goldschmidt controller.
// Clear has priority over increment. last_o flags that the iteration now in progress is
// the final one (count == ITERS-1).
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, count -> 0
//   clr_i  : synchronous clear
//   inc_i  : increment enable
//   cnt_o  : completed iterations
//   last_o : terminal-count flag
module gs_iter_counter #(
  parameter int unsigned ITERS = 3,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/goldschmidt_ctrl.sv
// Sequencing FSM for the Goldschmidt divider datapath. The single multiplier is shared
// between N and D on alternating cycles: IA scaling (N then D), then ITERS refinement
// passes (N then D, since K = 2 - newD must be taken before newD is overwritten).
// All outputs are Moore-decoded from the state register and iteration counter.
// Optional feature: define GOLDSCHMIDT_EARLY_TERM_EN to add input d_converged, which
// jumps from ITER_N straight to DONE once newD is exactly 1.0.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset, forces IDLE
//   start       : division request, sampled only in IDLE
//   d_converged : (optional) newD == 1.0 from the datapath
//   busy        : high in every state except IDLE
//   done        : one-cycle completion pulse
//   kSelect     : 0 = k from IA, 1 = k from 2 - newD
//   ndSelect    : multiplier operand select (D, N, newD, newN)
//   nEnable     : N result register load enable
//   dEnable     : D result register load enable
//   iter        : completed refinement iterations
module goldschmidt_ctrl
  import goldschmidt_pkg::*;
#(
  parameter int unsigned ITERS = 3,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef GOLDSCHMIDT_EARLY_TERM_EN
  input  logic             d_converged,
`endif
  output logic             busy,
  output logic             done,
  output logic             kSelect,
  output logic [1:0]       ndSelect,
  output logic             nEnable,
  output logic             dEnable,
  output logic [CNT_W-1:0] iter
);

  gs_state_t state_q, state_d;
  logic      cnt_last;
  logic      cnt_clr;
  logic      cnt_inc;

  // DONE always returns to IDLE, so clearing on DONE exit clears on IDLE entry.
  assign cnt_clr = (state_q == StDone);
  assign cnt_inc = (state_q == StIterD);

  gs_iter_counter #(
    .ITERS (ITERS),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (iter),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StInitN;
      StInitN: state_d = StInitD;
      StInitD: state_d = StIterN;
`ifdef GOLDSCHMIDT_EARLY_TERM_EN
      StIterN: state_d = d_converged ? StDone : StIterD;
`else
      StIterN: state_d = StIterD;
`endif
      StIterD: state_d = cnt_last ? StDone : StIterN;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    done     = 1'b0;
    kSelect  = KSEL_IA;
    ndSelect = ND_SEL_D;
    nEnable  = 1'b0;
    dEnable  = 1'b0;
    unique case (state_q)
      StInitN: begin
        ndSelect = ND_SEL_N;
        nEnable  = 1'b1;
      end
      StInitD: begin
        ndSelect = ND_SEL_D;
        dEnable  = 1'b1;
      end
      StIterN: begin
        kSelect  = KSEL_PREV;
        ndSelect = ND_SEL_NEWN;
        nEnable  = 1'b1;
      end
      StIterD: begin
        kSelect  = KSEL_PREV;
        ndSelect = ND_SEL_NEWD;
        dEnable  = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
